// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer sitting directly upstream of program_rom.
//
// Owns the program counter, drives the ROM address and latches the returned
// instruction into an instruction register. That register is presented
// downstream through a valid/ready handshake. Unconditional jumps are folded
// locally and are never issued. Fetch stalls on a conditional branch until
// execute resolves it.
//
// Ports:
//   clk          system clock; all state changes happen on the rising edge
//   rst          synchronous, active-high reset
//   run          fetch enable
//   rom_addr     address to program_rom; always equals pc
//   rom_data     instruction from program_rom, valid in the same cycle
//   ir           issued instruction
//   ir_pc        address that ir was fetched from
//   ir_valid     ir holds an instruction that has not been consumed yet
//   ir_ready     downstream accepts ir when ir_valid && ir_ready
//   br_resolve   one-cycle pulse from execute: the outstanding br is resolved
//   br_taken     qualifies br_resolve; 1 = taken
//   busy         sequencer is not idle
//   issue_count  number of completed ir handshakes, wraps around
module fetch_unit #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned INST_W  = 16,
   parameter logic [3:0]  OPC_JMP = 4'b1000,
   parameter logic [3:0]  OPC_BR  = 4'b1100,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_data,
   output logic [INST_W-1:0] ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ready,
   input  logic              br_resolve,
   input  logic              br_taken,
   output logic              busy,
   output logic [CNT_W-1:0]  issue_count
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StWaitBr = 2'd2
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] br_target_q;
   logic [INST_W-1:0] ir_q;
   logic [ADDR_W-1:0] ir_pc_q;
   logic              ir_valid_q;
   logic [CNT_W-1:0]  issue_count_q;

   logic              handshake;
   logic              slot_free;
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] pc_inc;

   assign handshake = ir_valid_q && ir_ready;
   // The register can take a new instruction when it is empty now or is being
   // drained in this same cycle.
   assign slot_free = !ir_valid_q || ir_ready;
   assign opcode    = rom_data[INST_W-1:INST_W-4];
   assign target    = rom_data[ADDR_W+7:8];
   assign pc_inc    = pc_q + ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         pc_q          <= '0;
         br_target_q   <= '0;
         ir_q          <= '0;
         ir_pc_q       <= '0;
         ir_valid_q    <= 1'b0;
         issue_count_q <= '0;
      end else begin
         if (handshake) begin
            issue_count_q <= issue_count_q + CNT_W'(1);
         end

         unique case (state_q)
            StIdle: begin
               // Nothing is fetched here, but a pending ir can still drain.
               if (handshake) begin
                  ir_valid_q <= 1'b0;
               end
               if (run) begin
                  state_q <= StFetch;
               end
            end

            StFetch: begin
               // When the slot is not free, ir, pc and state all hold.
               if (slot_free) begin
                  if (!run) begin
                     ir_valid_q <= 1'b0;
                     state_q    <= StIdle;
                  end else if (opcode == OPC_JMP) begin
                     // The jmp is folded here: redirect pc and leave a bubble.
                     pc_q       <= target;
                     ir_valid_q <= 1'b0;
                  end else begin
                     ir_q       <= rom_data;
                     ir_pc_q    <= pc_q;
                     ir_valid_q <= 1'b1;
                     pc_q       <= pc_inc;
                     if (opcode == OPC_BR) begin
                        br_target_q <= target;
                        state_q     <= StWaitBr;
                     end
                  end
               end
            end

            StWaitBr: begin
               if (handshake) begin
                  ir_valid_q <= 1'b0;
               end
               // pc already holds the fall-through address. Only a taken
               // branch redirects it. run is ignored until resolution.
               if (br_resolve) begin
                  if (br_taken) begin
                     pc_q <= br_target_q;
                  end
                  state_q <= StFetch;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign rom_addr    = pc_q;
   assign ir          = ir_q;
   assign ir_pc       = ir_pc_q;
   assign ir_valid    = ir_valid_q;
   assign busy        = (state_q != StIdle);
   assign issue_count = issue_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [3:0]  rom_addr;
   logic [15:0] rom_data;
   logic [15:0] ir;
   logic [3:0]  ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        br_resolve;
   logic        br_taken;
   logic        busy;
   logic [15:0] issue_count;
   logic        rom_sel;

   int total = 0;
   int bad   = 0;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .ir          (ir),
      .ir_pc       (ir_pc),
      .ir_valid    (ir_valid),
      .ir_ready    (ir_ready),
      .br_resolve  (br_resolve),
      .br_taken    (br_taken),
      .busy        (busy),
      .issue_count (issue_count)
   );

   always #5 clk = ~clk;

   // Fibonacci program image.
   function automatic logic [15:0] fib_rom(input logic [3:0] a);
      case (a)
         4'd0:    fib_rom = 16'h1E09;
         4'd1:    fib_rom = 16'h1201;
         4'd2:    fib_rom = 16'hB401;
         4'd3:    fib_rom = 16'hBE01;
         4'd4:    fib_rom = 16'hCA00;  // br -> 10
         4'd5:    fib_rom = 16'h2280;
         4'd6:    fib_rom = 16'h3301;
         4'd7:    fib_rom = 16'h4402;
         4'd8:    fib_rom = 16'hE5C0;
         4'd9:    fib_rom = 16'h8300;  // jmp 3
         4'd10:   fib_rom = 16'h0200;  // out r1
         4'd11:   fib_rom = 16'h8A00;  // jmp 10
         default: fib_rom = 16'h0000;
      endcase
   endfunction

   // Second image: nop with the address in the low bits, no jumps or branches.
   always_comb begin
      rom_data = fib_rom(rom_addr);
      if (rom_sel) rom_data = {12'h000, rom_addr};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One edge, then expect a freshly issued instruction.
   task automatic issue(input logic [3:0] pc, input logic [15:0] data, input logic [15:0] cnt);
      tick();
      chk("issue_valid", 32'(ir_valid), 32'd1);
      chk("issue_pc", 32'(ir_pc), 32'(pc));
      chk("issue_ir", 32'(ir), 32'(data));
      chk("issue_cnt", 32'(issue_count), 32'(cnt));
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; ir_ready = 1'b1;
      br_resolve = 1'b0; br_taken = 1'b0; rom_sel = 1'b0;
      tick();
      tick();
      chk("rst_pc", 32'(rom_addr), 32'd0);
      chk("rst_valid", 32'(ir_valid), 32'd0);
      chk("rst_cnt", 32'(issue_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ir", 32'(ir), 32'd0);

      // Straight-line issue at full rate, then a taken branch.
      rst = 1'b0; run = 1'b1;
      tick();
      chk("idle_to_fetch_busy", 32'(busy), 32'd1);
      chk("idle_no_fetch", 32'(ir_valid), 32'd0);
      issue(4'd0, 16'h1E09, 16'd0);
      issue(4'd1, 16'h1201, 16'd1);
      issue(4'd2, 16'hB401, 16'd2);
      issue(4'd3, 16'hBE01, 16'd3);
      issue(4'd4, 16'hCA00, 16'd4);
      tick();
      chk("br_cnt", 32'(issue_count), 32'd5);
      chk("br_wait_valid", 32'(ir_valid), 32'd0);
      chk("br_wait_addr", 32'(rom_addr), 32'd5);
      tick();
      chk("br_wait_addr2", 32'(rom_addr), 32'd5);
      chk("br_wait_valid2", 32'(ir_valid), 32'd0);
      br_resolve = 1'b1; br_taken = 1'b1;
      tick();
      br_resolve = 1'b0; br_taken = 1'b0;
      chk("br_taken_pc", 32'(rom_addr), 32'd10);
      chk("br_taken_valid", 32'(ir_valid), 32'd0);
      issue(4'd10, 16'h0200, 16'd5);

      // Tight loop 10/11: one issue every two cycles.
      tick();
      chk("loop_bubble", 32'(ir_valid), 32'd0);
      chk("loop_pc", 32'(rom_addr), 32'd10);
      issue(4'd10, 16'h0200, 16'd6);
      tick();
      chk("loop_bubble2", 32'(ir_valid), 32'd0);
      issue(4'd10, 16'h0200, 16'd7);

      // Restart, not-taken branch, backpressure, jmp at 9.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_cnt", 32'(issue_count), 32'd0);
      chk("rst2_pc", 32'(rom_addr), 32'd0);
      tick();
      issue(4'd0, 16'h1E09, 16'd0);
      issue(4'd1, 16'h1201, 16'd1);
      issue(4'd2, 16'hB401, 16'd2);
      issue(4'd3, 16'hBE01, 16'd3);
      issue(4'd4, 16'hCA00, 16'd4);
      tick();
      chk("br2_cnt", 32'(issue_count), 32'd5);
      tick();
      br_resolve = 1'b1; br_taken = 1'b0;
      tick();
      br_resolve = 1'b0;
      chk("br_nt_pc", 32'(rom_addr), 32'd5);
      chk("br_nt_valid", 32'(ir_valid), 32'd0);
      issue(4'd5, 16'h2280, 16'd5);
      ir_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_valid", 32'(ir_valid), 32'd1);
         chk("stall_ir", 32'(ir), 32'h2280);
         chk("stall_ir_pc", 32'(ir_pc), 32'd5);
         chk("stall_pc", 32'(rom_addr), 32'd6);
         chk("stall_cnt", 32'(issue_count), 32'd5);
      end
      ir_ready = 1'b1;
      issue(4'd6, 16'h3301, 16'd6);
      issue(4'd7, 16'h4402, 16'd7);
      issue(4'd8, 16'hE5C0, 16'd8);
      tick();
      chk("jmp_bubble", 32'(ir_valid), 32'd0);
      chk("jmp_target", 32'(rom_addr), 32'd3);
      chk("jmp_cnt", 32'(issue_count), 32'd9);
      issue(4'd3, 16'hBE01, 16'd9);
      issue(4'd4, 16'hCA00, 16'd10);
      chk("wait_fallthru", 32'(rom_addr), 32'd5);
      ir_ready = 1'b0;
      tick();
      chk("wait_held_valid", 32'(ir_valid), 32'd1);
      chk("wait_busy", 32'(busy), 32'd1);

      // Reset in the middle of a branch wait, then a stray resolve.
      rst = 1'b1;
      tick();
      rst = 1'b0; run = 1'b0;
      chk("midrst_pc", 32'(rom_addr), 32'd0);
      chk("midrst_valid", 32'(ir_valid), 32'd0);
      chk("midrst_cnt", 32'(issue_count), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      br_resolve = 1'b1; br_taken = 1'b1;
      tick();
      br_resolve = 1'b0; br_taken = 1'b0;
      chk("stray_res_pc", 32'(rom_addr), 32'd0);
      chk("stray_res_busy", 32'(busy), 32'd0);
      chk("stray_res_valid", 32'(ir_valid), 32'd0);

      // pc wraps from 15 to 0 on a jump-free image.
      ir_ready = 1'b1; rom_sel = 1'b1; run = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         issue(4'(i), 16'(i), 16'(i));
      end
      issue(4'd0, 16'd0, 16'd16);

      // run dropped in FETCH with a free slot: back to idle, pc preserved.
      run = 1'b0;
      tick();
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_valid", 32'(ir_valid), 32'd0);
      chk("stop_pc", 32'(rom_addr), 32'd1);
      chk("stop_cnt", 32'(issue_count), 32'd17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch sequencer directly upstream of program_rom: owns the program counter, drives the ROM address and latches the returned 16-bit instruction into an instruction register.
- Presents the instruction register to decode/execute through a valid/ready handshake.
- Folds unconditional jmp (opcode 1000) locally.
- Holds fetch on br (opcode 1100) until execute resolves the branch.

Parameters:
- ADDR_W, 4, PC/ROM address width; legal range 1..8; jump/branch target is instruction[ADDR_W+7:8].
- INST_W, 16, instruction width.
- OPC_JMP, 4'b1000, opcode (instruction[15:12]) folded as an unconditional jump.
- OPC_BR, 4'b1100, opcode treated as a conditional branch.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  fetch enable.
- rom_addr  out  ADDR_W  address to program_rom; equals pc combinationally.
- rom_data  in  INST_W  instruction from program_rom; valid in the same cycle as rom_addr.
- ir  out  INST_W  issued instruction.
- ir_pc  out  ADDR_W  address ir was fetched from.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  downstream accepts ir when ir_valid && ir_ready.
- br_resolve  in  1  one-cycle pulse from execute: outstanding br resolved.
- br_taken  in  1  qualifies br_resolve; 1 = taken.
- busy  out  1  state != IDLE.
- issue_count  out  CNT_W  number of completed ir handshakes.

Behaviour:
- Reset values (next edge with rst=1, from any state, including mid-WAIT_BR):
  - pc=0, ir=0, ir_pc=0, ir_valid=0, issue_count=0, br_target_q=0, state=IDLE.
  - rst overrides every other input.
- "Slot free" in a cycle = !ir_valid || ir_ready.
- Handshake: ir_valid, once high, stays high and ir/ir_pc stay stable until accepted. No drop, no duplicate.
- issue_count increments by 1 on each handshake and wraps modulo 2^CNT_W.
- States: IDLE, FETCH, WAIT_BR.
- IDLE:
  - No fetch; pc held.
  - run=1 -> FETCH on the next edge.
  - ir continues to drain normally.
- FETCH, slot not free: everything held (pc, ir, state).
- FETCH, slot free, run=0: no fetch; go IDLE; pc preserved; ir_valid cleared if the slot was consumed.
- FETCH, slot free, run=1, decode rom_data[15:12]:
  - OPC_JMP:
    - pc <= rom_data[ADDR_W+7:8].
    - jmp is not issued; ir_valid <= 0.
    - Costs exactly one bubble cycle.
  - OPC_BR:
    - ir <= rom_data, ir_pc <= pc, ir_valid <= 1.
    - br_target_q <= target field; pc <= pc+1.
    - Go WAIT_BR.
  - Other opcodes: ir <= rom_data, ir_pc <= pc, ir_valid <= 1, pc <= pc+1.
  - pc+1 wraps modulo 2^ADDR_W (15 -> 0).
- WAIT_BR:
  - No fetch; rom_addr still shows pc (the fall-through address).
  - br_resolve=1 and br_taken=1: pc <= br_target_q; go FETCH.
  - br_resolve=1 and br_taken=0: pc unchanged; go FETCH.
  - run is ignored until resolution; if run=0 at resolution, go FETCH anyway, which drops to IDLE on its next free slot.
  - br_resolve may arrive in the same cycle the br is accepted downstream, or later. It never arrives before the br is issued.
- br_resolve outside WAIT_BR: ignored.
- Back-to-back jmp (jmp to a jmp): one bubble per jmp.
- jmp to own address: loops forever with ir_valid=0; legal.
- Throughput: one instruction per cycle when ir_ready is held at 1 and there is no jmp or br.

Test Plan:
1. ROM holds the Fibonacci program; rst, then run=1, ir_ready=1 -> handshakes in order: (ir_pc 0, 0x1E09), (1, 0x1201), (2, 0xB401), (3, 0xBE01), (4, 0xCA00); issue_count=5.
2. jmp at address 9 (0x8300) -> ir_pc 8 (0xE5C0) issued, then one cycle with ir_valid=0, then ir_pc 3 (0xBE01); address 9 is never presented.
3. br at address 4: br_resolve with br_taken=1 pulsed 3 cycles after issue -> rom_addr=5 during the wait, no new ir; next issued ir_pc=10 (0x0200). Repeat with br_taken=0 -> next ir_pc=5 (0x2280).
4. ir_ready=0 for 4 cycles while ir=0x2280, ir_pc=5 -> ir, ir_pc, pc=6 and issue_count stable. Release -> ir_pc 6 then 7, no loss or duplicate.
5. Loop at 10/11 (out r1, jmp 10) -> ir_pc=10 issued every 2 cycles indefinitely. Separately, a ROM image with nops at 12..15 and no jmp -> pc wraps 15 -> 0.
6. rst pulsed one cycle while in WAIT_BR with ir_valid=1 -> next cycle pc=0, ir_valid=0, issue_count=0, busy=0. A subsequent br_resolve is ignored.
